// File: rtl/encoder_8b10b_pipe.sv
// Multi-lane pipelined 8b/10b encoder: valid/ready output stage, running-disparity
// chain across lanes, RD preload, alternate-7 selection and illegal-K accounting.
module encoder_8b10b_pipe #(
  parameter int unsigned BYTES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*BYTES-1:0]  d_in,
  input  logic [BYTES-1:0]    k_in,
  input  logic                rd_load,
  input  logic                rd_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [10*BYTES-1:0] d_out,
  output logic [BYTES-1:0]    k_err,
  output logic                rd_out,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int unsigned NB_W  = $clog2(BYTES + 1);
  localparam int unsigned SUM_W = CNT_W + NB_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // 5b/6b data code (abcdei, a at MSB) for an entering RD-.
  function automatic logic [5:0] code6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 5b/6b with RD: RD+ uses the complement for unbalanced codes and for D.7.
  function automatic logic [5:0] enc6(input logic [4:0] x, input logic k28, input logic rd);
    logic [5:0] c;
    c = k28 ? 6'b001111 : code6_neg(x);
    if (rd && (($countones(c) != 3) || (!k28 && (x == 5'd7)))) begin
      c = ~c;
    end
    return c;
  endfunction

  // 3b/4b (fghj) given the disparity after the 6b block and its e/i bits.
  function automatic logic [3:0] enc4(input logic [2:0] y, input logic k, input logic rd,
                                      input logic e, input logic i);
    logic [3:0] c;
    logic       flip;
    logic       a7;
    a7   = (!rd && e && i) || (rd && !e && !i);
    flip = rd;
    if (k) begin
      case (y)
        3'd0:    c = 4'b1011;
        3'd1:    c = 4'b0110;
        3'd2:    c = 4'b1010;
        3'd3:    c = 4'b1100;
        3'd4:    c = 4'b1101;
        3'd5:    c = 4'b0101;
        3'd6:    c = 4'b1001;
        default: c = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0:    c = 4'b1011;
        3'd1:    c = 4'b1001;
        3'd2:    c = 4'b0101;
        3'd3:    c = 4'b1100;
        3'd4:    c = 4'b1101;
        3'd5:    c = 4'b1010;
        3'd6:    c = 4'b0110;
        default: c = a7 ? 4'b0111 : 4'b1110;
      endcase
      // Neutral data codes other than x.3 are identical in both columns.
      flip = rd && ((y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7));
    end
    return flip ? ~c : c;
  endfunction

  // K28.y and K23/27/29/30.7 are the only encodable control codes.
  function automatic logic is_legal_k(input logic [7:0] b);
    logic [4:0] x;
    logic [2:0] y;
    x = b[4:0];
    y = b[7:5];
    return (x == 5'd28) ||
           ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  // One lane: returns {ending RD, abcdei_fghj}.
  function automatic logic [10:0] enc_lane(input logic [7:0] b, input logic k, input logic rd);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rd10;
    c6   = enc6(b[4:0], k && (b[4:0] == 5'd28), rd);
    rd6  = ($countones(c6) == 3) ? rd : ~rd;
    c4   = enc4(b[7:5], k, rd6, c6[1], c6[0]);
    rd10 = ($countones(c4) == 2) ? rd6 : ~rd6;
    return {rd10, c6, c4};
  endfunction

  logic                accept;
  logic                rd_run;
  logic                legal;
  logic [10:0]         lane;
  logic [10*BYTES-1:0] word_c;
  logic [BYTES-1:0]    bad_c;
  logic                rd_end_c;
  logic [NB_W-1:0]     n_bad_c;
  logic [SUM_W-1:0]    cnt_sum_c;
  logic [CNT_W-1:0]    cnt_next_c;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Encode all lanes, chaining disparity from lane 0 upward.
  always_comb begin
    word_c = '0;
    bad_c  = '0;
    legal  = 1'b0;
    lane   = '0;
    rd_run = rd_load ? rd_val : rd_out;
    for (int unsigned n = 0; n < BYTES; n++) begin
      legal    = k_in[n] && is_legal_k(d_in[8*n +: 8]);
      bad_c[n] = k_in[n] && !legal;
      lane     = enc_lane(d_in[8*n +: 8], legal, rd_run);
      word_c[10*n +: 10] = lane[9:0];
      rd_run   = lane[10];
    end
    rd_end_c = rd_run;
  end

  // Saturating add of this word's illegal-K lane count.
  always_comb begin
    n_bad_c    = NB_W'($countones(bad_c));
    cnt_sum_c  = SUM_W'(err_cnt) + SUM_W'(n_bad_c);
    cnt_next_c = (cnt_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum_c);
  end

  // Output stage, RD register and error counter; everything holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      k_err     <= '0;
      rd_out    <= 1'b0;
      err_cnt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      d_out     <= word_c;
      k_err     <= bad_c;
      rd_out    <= rd_end_c;
      err_cnt   <= cnt_next_c;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (rd_load) begin
        rd_out <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_encoder_8b10b_pipe.sv
// Bench for encoder_8b10b_pipe: a 2-lane/16-bit-counter instance and a 1-lane/2-bit-counter
// instance share stimulus (lane 0) and are checked every cycle against a table-driven model.
module tb_encoder_8b10b_pipe;

  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                     8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready, rd_load, rd_val;
  logic [15:0] d_in;
  logic [1:0]  k_in;
  logic        in_ready, out_valid, rd_out;
  logic [19:0] d_out;
  logic [1:0]  k_err;
  logic [15:0] err_cnt;
  logic        in_ready1, out_valid1, rd_out1, k_err1;
  logic [9:0]  d_out1;
  logic [1:0]  err_cnt1;

  logic        m_valid, m_rd, m_rd1, m_kerr1;
  logic [19:0] m_dout;
  logic [9:0]  m_dout1;
  logic [1:0]  m_kerr;
  int          m_cnt, m_cnt1;
  logic        checking;
  int          n_checks, n_errors;

  encoder_8b10b_pipe #(.BYTES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .k_in(k_in), .rd_load(rd_load), .rd_val(rd_val),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .k_err(k_err),
    .rd_out(rd_out), .err_cnt(err_cnt));

  encoder_8b10b_pipe #(.BYTES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .d_in(d_in[7:0]), .k_in(k_in[0]), .rd_load(rd_load), .rd_val(rd_val),
    .out_valid(out_valid1), .out_ready(out_ready), .d_out(d_out1), .k_err(k_err1),
    .rd_out(rd_out1), .err_cnt(err_cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal_k(input logic [7:0] b);
    for (int j = 0; j < 12; j++) if (KL[j] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Reference lane encoder: {ending RD, 10-bit code} from the standard code tables.
  function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic k, input logic rd);
    int         x, y, ones;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6, kk;
    x  = int'(b[4:0]);
    y  = int'(b[7:5]);
    kk = k && legal_k(b);
    if (kk && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
    else               c6 = rd ? T6P[x] : T6N[x];
    rd6 = ($countones(c6) == 3) ? rd : ($countones(c6) > 3);
    if (kk) c4 = rd6 ? K4P[y] : K4N[y];
    else if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                        (rd6 && (x == 11 || x == 13 || x == 14))))
      c4 = rd6 ? 4'b1000 : 4'b0111;
    else c4 = rd6 ? D4P[y] : D4N[y];
    ones = $countones({c6, c4});
    return {(ones == 5) ? rd : (ones > 5), c6, c4};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_dout = '0; m_kerr = '0; m_rd = 1'b0; m_cnt = 0;
    m_dout1 = '0; m_kerr1 = 1'b0; m_rd1 = 1'b0; m_cnt1 = 0;
  endtask

  // Model state advance for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [10:0] enc;
    logic        rd;
    int          nbad;
    if (in_valid && (!m_valid || out_ready)) begin
      rd   = rd_load ? rd_val : m_rd;
      nbad = 0;
      for (int n = 0; n < 2; n++) begin
        enc = ref_enc(d_in[8*n +: 8], k_in[n], rd);
        m_dout[10*n +: 10] = enc[9:0];
        rd = enc[10];
        m_kerr[n] = k_in[n] && !legal_k(d_in[8*n +: 8]);
        if (m_kerr[n]) nbad++;
      end
      m_rd  = rd;
      m_cnt = (m_cnt + nbad > 65535) ? 65535 : m_cnt + nbad;
      enc     = ref_enc(d_in[7:0], k_in[0], rd_load ? rd_val : m_rd1);
      m_dout1 = enc[9:0];
      m_rd1   = enc[10];
      m_kerr1 = k_in[0] && !legal_k(d_in[7:0]);
      m_cnt1  = (m_cnt1 + int'(m_kerr1) > 3) ? 3 : m_cnt1 + int'(m_kerr1);
      m_valid = 1'b1;
    end else begin
      if (out_ready) m_valid = 1'b0;
      if (rd_load) begin
        m_rd  = rd_val;
        m_rd1 = rd_val;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic send(input logic [7:0] b1, input logic [7:0] b0, input logic [1:0] k,
                      input logic ld, input logic vl);
    in_valid = 1'b1; d_in = {b1, b0}; k_in = k; rd_load = ld; rd_val = vl; out_ready = 1'b1;
    step();
    in_valid = 1'b0; rd_load = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_d_out"},     64'(d_out), 64'(0));
    check({tag, "_k_err"},     64'(k_err), 64'(0));
    check({tag, "_rd_out"},    64'(rd_out), 64'(0));
    check({tag, "_err_cnt"},   64'(err_cnt), 64'(0));
    check({tag, "_in_ready"},  64'(in_ready), 64'(1));
    check({tag, "_err_cnt1"},  64'(err_cnt1), 64'(0));
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("in_ready",  64'(in_ready), 64'(!m_valid || out_ready));
      check("d_out",     64'(d_out), 64'(m_dout));
      check("k_err",     64'(k_err), 64'(m_kerr));
      check("rd_out",    64'(rd_out), 64'(m_rd));
      check("err_cnt",   64'(err_cnt), 64'(m_cnt));
      check("out_valid1", 64'(out_valid1), 64'(m_valid));
      check("in_ready1",  64'(in_ready1), 64'(!m_valid || out_ready));
      check("d_out1",     64'(d_out1), 64'(m_dout1));
      check("k_err1",     64'(k_err1), 64'(m_kerr1));
      check("rd_out1",    64'(rd_out1), 64'(m_rd1));
      check("err_cnt1",   64'(err_cnt1), 64'(m_cnt1));
    end
  end

  initial begin
    logic [7:0] b;
    logic       kk;
    checking = 1'b0; n_checks = 0; n_errors = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rd_load = 1'b0; rd_val = 1'b0;
    d_in = '0; k_in = '0;
    model_reset();

    check("model_D0.0",    64'(ref_enc(8'h00, 1'b0, 1'b0)), 64'({1'b0, 10'h274}));
    check("model_K28.5m",  64'(ref_enc(8'hBC, 1'b1, 1'b0)), 64'({1'b1, 10'h0FA}));
    check("model_K28.5p",  64'(ref_enc(8'hBC, 1'b1, 1'b1)), 64'({1'b0, 10'h305}));
    check("model_D11.7p",  64'(ref_enc(8'hEB, 1'b0, 1'b1)), 64'({1'b0, 10'h348}));
    check("model_D11.7m",  64'(ref_enc(8'hEB, 1'b0, 1'b0)), 64'({1'b1, 10'h34E}));

    #1 rst_n = 1'b0;
    #1 checking = 1'b1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    send(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    check("d0_d_out1", 64'(d_out1), 64'(10'h274));
    check("d0_rd_out1", 64'(rd_out1), 64'(0));
    check("d0_d_out", 64'(d_out), 64'(20'h9D274));

    send(8'hB5, 8'hBC, 2'b01, 1'b1, 1'b0);
    check("k285_d_out", 64'(d_out), 64'(20'hAA8FA));
    check("k285_rd_out", 64'(rd_out), 64'(1));
    check("k285_k_err", 64'(k_err), 64'(0));
    check("k285_d_out1", 64'(d_out1), 64'(10'h0FA));
    check("k285_rd_out1", 64'(rd_out1), 64'(1));
    send(8'hB5, 8'hBC, 2'b01, 1'b0, 1'b0);
    check("k285b_d_out1", 64'(d_out1), 64'(10'h305));
    check("k285b_rd_out1", 64'(rd_out1), 64'(0));

    send(8'h00, 8'hEB, 2'b00, 1'b1, 1'b1);
    check("a7_d_out1", 64'(d_out1), 64'(10'h348));
    send(8'h00, 8'hEB, 2'b00, 1'b1, 1'b0);
    check("p7_d_out1", 64'(d_out1), 64'(10'h34E));

    send(8'h00, 8'h00, 2'b01, 1'b1, 1'b0);
    send(8'h00, 8'h00, 2'b01, 1'b1, 1'b0);
    check("badk_k_err", 64'(k_err), 64'(2'b01));
    check("badk_k_err1", 64'(k_err1), 64'(1));
    check("badk_d_out1", 64'(d_out1), 64'(10'h274));
    check("badk_err_cnt", 64'(err_cnt), 64'(2));
    check("badk_err_cnt1", 64'(err_cnt1), 64'(2));
    repeat (3) send(8'h00, 8'h00, 2'b01, 1'b1, 1'b0);
    check("sat_err_cnt1", 64'(err_cnt1), 64'(3));
    check("sat_err_cnt", 64'(err_cnt), 64'(5));
    send(8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
    check("two_err_cnt", 64'(err_cnt), 64'(7));

    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d_in = 16'($urandom); k_in = 2'b00;
      step();
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d_in = 16'($urandom);
      step();
    end

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        in_valid = 1'b1; out_ready = 1'b0; rd_load = 1'b0;
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("midrst");
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rd_load   = ($urandom_range(0, 15) == 0);
      rd_val    = 1'($urandom_range(0, 1));
      for (int n = 0; n < 2; n++) begin
        b  = 8'($urandom);
        kk = 1'b0;
        case ($urandom_range(0, 7))
          0: kk = 1'b1;
          1: begin kk = 1'b1; b = KL[$urandom_range(0, 11)]; end
          default: kk = 1'b0;
        endcase
        d_in[8*n +: 8] = b;
        k_in[n] = kk;
      end
      step();
    end

    in_valid = 1'b0; rd_load = 1'b0; out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder_8b10b_pipe.md
# encoder_8b10b_pipe

Parametrised, pipelined 8b/10b encoder. Each accepted word carries BYTES bytes, each with its own K flag. A running-disparity (RD) chain runs across the lanes of the word and is registered between words. The block sits between the framing logic and the serializer. It adds valid/ready flow control, RD preload, alternate-7 selection, illegal-K detection and a saturating error counter, none of which the single-lane combinational 3b/4b and 5b/6b encoders provide.

## Interface
- BYTES, 2, bytes encoded per accepted word (1..8)
- CNT_W, 16, width of the illegal-K error counter
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  input word valid
- IN_READY  out  1  block can accept a word this cycle
- D_IN  in  8*BYTES  lane n at bits [8n+7:8n], HGFEDCBA order
- K_IN  in  BYTES  lane n requests a control code
- RD_LOAD  in  1  one-cycle pulse: preload RD with RD_VAL
- RD_VAL  in  1  preload value (0 = negative, 1 = positive)
- OUT_VALID  out  1  encoded word valid
- OUT_READY  in  1  downstream accepts the word
- D_OUT  out  10*BYTES  lane n at bits [10n+9:10n], abcdei_fghj with a at MSB; lane 0 transmitted first
- K_ERR  out  BYTES  lane n of D_OUT was an illegal K request
- RD_OUT  out  1  current registered RD (ending disparity of the last accepted word)
- ERR_CNT  out  CNT_W  saturating count of illegal-K lanes

## Operation
- Accept: IN_VALID & IN_READY.
- IN_READY = ~OUT_VALID | OUT_READY. This is a single output-register pipeline stage with no combinational path from IN_VALID to OUT_VALID.
- Per lane, the 5b/6b and 3b/4b codes follow standard IBM 8b/10b.
  - Lane 0 starts from the registered RD.
  - Lane n+1 starts from lane n's ending disparity.
  - The ending disparity of the last lane is written to the RD register on accept.
- Alternate 7 (A7):
  - Applies to D.x.7 when RD- and e=i=1, or RD+ and e=i=0.
  - K28.7 and the other legal K.x.7 codes always use the K encoding.
- Legal K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
- Illegal K request (K_IN=1 on any other byte):
  - The byte is encoded as the data byte.
  - The matching K_ERR bit is set, registered with D_OUT.
  - ERR_CNT increases by the number of illegal lanes in the word and saturates at 2^CNT_W-1.
- RD_LOAD:
  - Without an accept in the same cycle: RD is set to RD_VAL.
  - With an accept in the same cycle: lane 0 of the accepted word starts from RD_VAL, and RD is then set to the word's ending disparity.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, D_OUT, K_ERR and OUT_VALID hold, and RD and ERR_CNT do not change except through RD_LOAD.
- ERR_CNT is cleared only by reset.

## Timing
- Reset values: OUT_VALID=0, D_OUT=0, K_ERR=0, RD register=0 (RD-), RD_OUT=0, ERR_CNT=0, IN_READY=1 (follows from OUT_VALID=0).
- Latency: a word accepted at edge t appears on D_OUT with OUT_VALID=1 after edge t.
- Throughput: one word per cycle when OUT_READY=1.
- OUT_VALID falls after an edge with OUT_READY=1 and no accept. It stays 1 with the new word if an accept occurs in the same cycle.
- RD_OUT and ERR_CNT update on the same edge as D_OUT.
- Reset deassertion mid-stream: the first word after reset starts from RD-. An in-flight word is discarded without being delivered.

## Test plan
- Reset, BYTES=1, D_IN=0x00, K_IN=0 -> D_OUT=0x274 one cycle after accept; RD_OUT=0.
- RD-, K28.5 (0xBC, K=1), then K28.5 again -> D_OUT=0x0FA, RD_OUT=1; then 0x305, RD_OUT=0.
- BYTES=2, RD-, D_IN=0xB5BC, K_IN=2'b01 -> D_OUT=20'hAA8FA, RD_OUT=1, K_ERR=0.
- D11.7 (0xEB) with RD_LOAD/RD_VAL=1 in the accept cycle -> D_OUT=0x348. The same byte from RD- -> 0x34E.
- K_IN=1 with D_IN=0x00 on two consecutive words -> K_ERR lane bit set each word, encoding as for D.0.0; ERR_CNT=2. With CNT_W=2, 5 such lanes -> ERR_CNT=3.
- Hold OUT_READY=0 for 4 cycles with IN_VALID=1 -> IN_READY=0, D_OUT stable, RD_OUT unchanged. Release -> the queued words are delivered in order with a correct RD chain. Asserting RST_N=0 mid-stream -> all outputs return to their reset values immediately.
